// File: rtl/digit_feeder_if.sv
// digit_feeder_if: conversion request (value/start) and the (pos,dig) write port
// that the seven-segment display controller samples every clock.
interface digit_feeder_if #(parameter int WIDTH = 27);
    logic [WIDTH-1:0] value;
    logic             start;
    logic             busy;
    logic             wr;
    logic [3:0]       pos;
    logic [3:0]       dig;
    logic             done;
    logic             overflow;
    modport master (output value, start, input busy, wr, pos, dig, done, overflow);
    modport slave  (input value, start, output busy, wr, pos, dig, done, overflow);
endinterface

// File: rtl/digit_feeder.sv
// digit_feeder: sequential double-dabble binary-to-BCD, then one (pos,dig) display
// write per cycle, least-significant digit first; saturates to all nines on overflow.
module digit_feeder #(
    parameter int WIDTH = 27,
    parameter int NDIG  = 8
) (
    input logic           clock,
    input logic           reset,
    digit_feeder_if.slave bus
);
    localparam int          CW    = $clog2((WIDTH > NDIG ? WIDTH : NDIG) + 1);
    localparam logic [63:0] LIMIT = 64'd10 ** NDIG;

    typedef enum logic [1:0] {IDLE, CONV, EMIT} state_t;

    state_t              r_state, w_next;
    logic [WIDTH-1:0]    r_bin;
    logic [4*NDIG-1:0]   r_bcd, w_adj;
    logic [CW-1:0]       r_cnt;
    logic                r_ovf, r_done;
    logic                w_accept, w_last_step, w_last_wr, w_wr;

    assign w_accept    = r_state == IDLE && bus.start;
    assign w_last_step = r_cnt == CW'(WIDTH - 1);
    assign w_last_wr   = r_cnt == CW'(NDIG - 1);
    assign w_wr        = r_state == EMIT;

    always_ff @(posedge clock or negedge reset)
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;

    always_comb begin
        w_next = r_state == IDLE ? (bus.start   ? CONV : IDLE) :
                 r_state == CONV ? (w_last_step ? EMIT : CONV) :
                 r_state == EMIT ? (w_last_wr   ? IDLE : EMIT) : IDLE;
    end

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < NDIG; i++)
            w_adj[4*i +: 4] = r_bcd[4*i +: 4] >= 4'd5 ? r_bcd[4*i +: 4] + 4'd3 : r_bcd[4*i +: 4];
    end

    // Carry out of the top BCD nibble is dropped; overflow forces the output to nines.
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_wr && w_last_wr;
            if (w_accept) begin
                r_bin <= bus.value;
                r_bcd <= '0;
                r_cnt <= '0;
                r_ovf <= 64'(bus.value) >= LIMIT;
            end else if (r_state == CONV) begin
                {r_bcd, r_bin} <= {w_adj[4*NDIG-2:0], r_bin, 1'b0};
                r_cnt          <= w_last_step ? '0 : r_cnt + 1'b1;
            end else if (w_wr) begin
                r_bcd <= r_bcd >> 4;
                r_cnt <= r_cnt + 1'b1;
            end
        end

    assign bus.busy     = r_state != IDLE;
    assign bus.wr       = w_wr;
    assign bus.pos      = w_wr ? 4'(r_cnt) : 4'd0;
    assign bus.dig      = !w_wr ? 4'd0 : r_ovf ? 4'd9 : r_bcd[3:0];
    assign bus.done     = r_done;
    assign bus.overflow = r_ovf;
endmodule

// File: doc/digit_feeder.md
# digit_feeder

Producer side of the 8-digit seven-segment display write port. It converts a binary value, captured on a start strobe, into decimal digits using sequential double-dabble. It then issues one `(pos, dig)` write per cycle, least-significant digit first, on the same `pos`/`dig` port that the display controller samples every clock. It sits between datapath logic (counters, measurement results) and the display controller, so the controller receives only legal writes (`pos < 8`, `dig < 10`).

## Interface
Parameters:
- `WIDTH`, default 27: binary input width. The default covers 0..99_999_999.
- `NDIG`, default 8: number of digits emitted (1..8). `pos` runs 0..`NDIG-1`.

Ports:
- `clock`, input, 1: single clock. All state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `value`, input, `WIDTH`: binary value. Sampled only on the accepted `start` edge.
- `start`, input, 1: request a conversion. Accepted only in IDLE.
- `busy`, output, 1: high from the cycle after acceptance until the last write.
- `wr`, output, 1: high for exactly `NDIG` consecutive cycles per conversion. Marks the cycles where `pos`/`dig` carry a write.
- `pos`, output, 4: digit position of the current write.
- `dig`, output, 4: BCD digit, always 0..9.
- `done`, output, 1: one-cycle pulse after the last write.
- `overflow`, output, 1: set if the captured value ≥ 10^`NDIG`. Held until the next accepted start.

## Operation
States:
- IDLE: `busy=0`. `start=1` latches `value` into the shift register, clears the BCD register, computes `overflow` and goes to CONV.
- CONV: one double-dabble step per cycle for `WIDTH` cycles.
  - Each step: add 3 to every BCD nibble that is ≥ 5, then shift `{bcd, bin}` left by 1.
  - The BCD register is 4·`NDIG` bits. Any bits shifted out of its top are discarded.
  - After `WIDTH` steps, go to EMIT.
- EMIT: emit `NDIG` writes, one per cycle, on consecutive cycles.
  - Write i (i = 0..`NDIG-1`) has `pos=i`, `dig` = BCD nibble i, `wr=1`.
  - If `overflow=1`, every `dig` is 9 (display saturates at 99999999).
  - After write `NDIG-1`, go to IDLE and pulse `done`.

Rules:
- `start` while `busy=1` is ignored. It is neither queued nor does it alter `value` capture.
- `start` in the `done` cycle (state IDLE) is accepted; back-to-back conversions are legal.
- When `wr=0`, `pos` and `dig` are driven to 0. The display controller samples every clock, so a write to position 0 with digit 0 is unavoidable. Integration must gate the controller with `wr` or treat the idle value as benign. This block still guarantees `dig<10` and `pos<NDIG` at all times.
- Leading zeros are emitted as 0. There is no blanking code.
- `overflow` compare: `value` ≥ 10^`NDIG`, evaluated at the accept edge as a constant-width compare.

Reset (asynchronous, `reset=0`), effective immediately without a clock:
- `busy=0`, `wr=0`, `pos=0`, `dig=0`, `done=0`, `overflow=0`.
- State returns to IDLE; the shift and BCD registers clear.
- Reset mid-CONV or mid-EMIT aborts the conversion. No further `wr` and no `done` are produced.
- After `reset` rises, the first `start` is accepted normally.

## Timing
All timing is relative to the rising edge E0 where `start=1` is sampled in IDLE. Let W = `WIDTH` and N = `NDIG`.

| Cycles after E0 | State | Outputs |
|---|---|---|
| 1..W | CONV | `busy=1`, `wr=0` |
| W+1..W+N | EMIT | `busy=1`, `wr=1`, `pos`=0..N-1 in order |
| W+N+1 | IDLE | `busy=0`, `done=1` |

- `overflow` is valid from cycle 1.
- Total latency from start to `done` is W+N+1 cycles: 36 at defaults.
- Maximum throughput is one conversion per W+N+1 cycles.

## Test plan
- `value`=12_345_678, start: `wr` high cycles 28..35 with `(pos,dig)` = (0,8)(1,7)(2,6)(3,5)(4,4)(5,3)(6,2)(7,1). `done` at cycle 36. `overflow`=0.
- `value`=0, then `value`=99_999_999 back-to-back (second start in the `done` cycle): eight writes of 0, then eight writes of 9. The second `done` arrives exactly 36 cycles after the first.
- `value`=100_000_000: `overflow`=1 from cycle 1. All eight writes have `dig`=9. `overflow` clears on the next start with `value`=5, which emits 5,0,0,0,0,0,0,0.
- `start` pulsed at cycles 5 and 30 during a conversion of 42: both are ignored. Writes are 2,4,0,0,0,0,0,0; one `done`; `value` changes during busy have no effect.
- `reset` low at cycle 30 (mid-EMIT): all outputs 0 asynchronously. No further `wr`; no `done`. After release, start with 7 gives a normal 36-cycle conversion.
- Randomised `value` in 0..2^27-1 (1000 runs) against a reference model: `dig<10` and `pos<8` every cycle, and `wr` count = 8 per conversion.
